vmem_sequencer: RTL and testbench

Execute-stage sequencer directly downstream of the instruction decoder. It consumes functype, cycleCount, offset and register addresses for vector memory ops (VLD/VST). It then drives one memory access per vector element and the vector register file element-write port, and holds fetch/decode stalled for the instruction's multi-cycle duration. All other opcodes pass through without stalling.

---
 rtl/cvp14_pkg.sv | 30 +++
 rtl/vmem_sequencer.sv | 154 +++++++++++++++
 tb/tb_vmem_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 decode/execute front end: opcodes, vector
// length, vector-memory sequencer state encoding and its cycle counts.
package cvp14_pkg;

  localparam int VLEN = 16;

  localparam logic [3:0] VADD = 4'b0000;
  localparam logic [3:0] VDOT = 4'b0001;
  localparam logic [3:0] SMUL = 4'b0010;
  localparam logic [3:0] SST  = 4'b0011;
  localparam logic [3:0] VLD  = 4'b0100;
  localparam logic [3:0] VST  = 4'b0101;
  localparam logic [3:0] SLL  = 4'b0110;
  localparam logic [3:0] SLH  = 4'b0111;
  localparam logic [3:0] J    = 4'b1000;
  localparam logic [3:0] NOP  = 4'b1111;

  localparam logic [4:0] VLD_CYCLES = 5'd16;
  localparam logic [4:0] VST_CYCLES = 5'd15;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  function automatic logic is_vmem_op(input logic [3:0] op);
    return (op == VLD) || (op == VST);
  endfunction

endpackage

// File: rtl/vmem_sequencer.sv
// Execute-stage sequencer for vector loads/stores: one memory access per element.
// Optional stall-cycle performance counter enabled by defining VMEM_SEQ_PERF_CNT_EN.
module vmem_sequencer
  import cvp14_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [3:0]        functype,
  input  logic [4:0]        cycle_count,
  input  logic [5:0]        offset,
  input  logic [ADDR_W-1:0] base_data,
  input  logic [2:0]        vdst_addr,
  input  logic [2:0]        vsrc_addr,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [2:0]        vrf_raddr,
  output logic [3:0]        vrf_relem,
  input  logic [ADDR_W-1:0] vrf_rdata,
  output logic              vrf_we,
  output logic [2:0]        vrf_waddr,
  output logic [3:0]        vrf_welem,
  output logic [ADDR_W-1:0] vrf_wdata,
  output logic              busy,
  output logic [15:0]       perf_stall_cnt
);

  localparam logic [4:0] ELEMS = 5'(VLEN);

  seq_state_e        state_r, state_s;
  logic [4:0]        rem_r, idx_r;
  logic [ADDR_W-1:0] ea_r, ea_s;
  logic              is_vst_r;
  logic [2:0]        vdst_r, vsrc_r;
  logic              accept_s;

  // Gating with rst_n keeps stall low while reset is held, even with a memory op presented.
  assign accept_s = rst_n && (state_r == IDLE) && instr_valid && is_vmem_op(functype);
  assign ea_s     = base_data + {{(ADDR_W-6){offset[5]}}, offset};
  assign busy     = (state_r == RUN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched operation, effective address and cycle/element counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_r     <= '0;
      rem_r    <= 5'd0;
      idx_r    <= 5'd0;
      is_vst_r <= 1'b0;
      vdst_r   <= 3'd0;
      vsrc_r   <= 3'd0;
    end else if (accept_s) begin
      ea_r     <= ea_s;
      rem_r    <= cycle_count;
      idx_r    <= 5'd0;
      is_vst_r <= (functype == VST);
      vdst_r   <= vdst_addr;
      vsrc_r   <= vsrc_addr;
    end else if (state_r == RUN) begin
      rem_r    <= (rem_r != 5'd0) ? rem_r - 5'd1 : 5'd0;
      idx_r    <= idx_r + 5'd1;
    end else begin
      rem_r    <= rem_r;
      idx_r    <= idx_r;
    end
  end

  // Next state and per-cycle memory / register-file strobes
  always_comb begin
    state_s   = state_r;
    stall     = 1'b0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    vrf_raddr = 3'd0;
    vrf_relem = 4'd0;
    vrf_we    = 1'b0;
    vrf_waddr = 3'd0;
    vrf_welem = 4'd0;
    vrf_wdata = '0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          stall   = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        stall   = (rem_r != 5'd0);
        state_s = (rem_r == 5'd0) ? IDLE : RUN;
        if (idx_r < ELEMS) begin
          mem_addr = ea_r + ADDR_W'(idx_r);
          if (is_vst_r) begin
            mem_we    = 1'b1;
            vrf_raddr = vsrc_r;
            vrf_relem = idx_r[3:0];
            mem_wdata = vrf_rdata;
          end else begin
            mem_re    = 1'b1;
          end
        end else begin
          mem_addr = '0;
        end
        // Load data arrives one cycle after its read, so the write trails by one element.
        if (!is_vst_r && (idx_r != 5'd0) && (idx_r <= ELEMS)) begin
          vrf_we    = 1'b1;
          vrf_waddr = vdst_r;
          vrf_welem = 4'(idx_r - 5'd1);
          vrf_wdata = mem_rdata;
        end else begin
          vrf_we    = 1'b0;
        end
      end
      default: state_s = IDLE;
    endcase
  end

`ifdef VMEM_SEQ_PERF_CNT_EN
  logic [15:0] perf_r;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_r <= 16'd0;
    end else if (stall && (perf_r != 16'hFFFF)) begin
      perf_r <= perf_r + 16'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_stall_cnt = perf_r;
`else
  assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vmem_sequencer.sv
// Randomized self-checking bench for vmem_sequencer against a cycle-trace model
// derived from the op rules (stall span, access window, load write lag).
module tb_vmem_sequencer;
  import cvp14_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [3:0]  functype;
  logic [4:0]  cycle_count;
  logic [5:0]  offset;
  logic [15:0] base_data;
  logic [2:0]  vdst_addr, vsrc_addr;
  logic        stall, mem_re, mem_we, vrf_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, vrf_rdata, vrf_wdata, perf_stall_cnt;
  logic [2:0]  vrf_raddr, vrf_waddr;
  logic [3:0]  vrf_relem, vrf_welem;

  int          checks = 0;
  int          errors = 0;
  int          exp_stalls = 0;
  logic [15:0] ld_key = 16'h5555;

  vmem_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .functype(functype),
    .cycle_count(cycle_count), .offset(offset), .base_data(base_data),
    .vdst_addr(vdst_addr), .vsrc_addr(vsrc_addr), .stall(stall),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vrf_raddr(vrf_raddr), .vrf_relem(vrf_relem),
    .vrf_rdata(vrf_rdata), .vrf_we(vrf_we), .vrf_waddr(vrf_waddr),
    .vrf_welem(vrf_welem), .vrf_wdata(vrf_wdata), .busy(busy),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // Data memory: contents are address ^ key, returned the cycle after the read.
  always @(posedge clk) mem_rdata <= mem_re ? (mem_addr ^ ld_key) : 16'hDEAD;

  // Vector register file: register r, element e holds 0xA000 + 16*r + e.
  assign vrf_rdata = 16'hA000 + {9'd0, vrf_raddr, vrf_relem};

  function automatic int perf_expect();
`ifdef VMEM_SEQ_PERF_CNT_EN
    return (exp_stalls > 65535) ? 65535 : exp_stalls;
`else
    return 0;
`endif
  endfunction

  // Runs one VLD/VST from acceptance to its final RUN cycle, checking every cycle.
  task automatic exec_op(input logic st, input logic [15:0] base, input logic [5:0] off,
                         input logic [4:0] cc, input logic [2:0] vd, input logic [2:0] vs);
    int ea, so, n;
    so = (int'(off) >= 32) ? int'(off) - 64 : int'(off);
    ea = (int'(base) + so + 65536) % 65536;
    n  = int'(cc);
    for (int t = 0; t <= n + 1; t++) begin
      int k;
      logic [4:0]  e_ctrl, o_ctrl;
      logic [15:0] e_addr, e_data;
      @(negedge clk);
      instr_valid = 1'b1;
      functype    = st ? VST : VLD;
      if (t == 0) begin
        base_data = base; offset = off; cycle_count = cc; vdst_addr = vd; vsrc_addr = vs;
      end else begin
        base_data = 16'($urandom); offset = 6'($urandom); cycle_count = 5'($urandom);
        vdst_addr = 3'($urandom); vsrc_addr = 3'($urandom);
      end
      #1;
      k = t - 1;
      e_ctrl = {(t <= n), (t >= 1), (st && k >= 0 && k < VLEN),
                (!st && k >= 0 && k < VLEN), (!st && k >= 1 && k <= VLEN)};
      o_ctrl = {stall, busy, mem_we, mem_re, vrf_we};
      checks++;
      if (o_ctrl !== e_ctrl) begin
        errors++;
        $display("FAIL ctrl t=%0d {stall,busy,we,re,vwe} got %b exp %b", t, o_ctrl, e_ctrl);
      end
      if (e_ctrl[2] || e_ctrl[1]) begin
        e_addr = 16'((ea + k) % 65536);
        checks++;
        if (mem_addr !== e_addr) begin
          errors++;
          $display("FAIL mem_addr t=%0d got %h exp %h", t, mem_addr, e_addr);
        end
      end
      if (e_ctrl[2]) begin
        e_data = 16'(32'hA000 + 16 * int'(vs) + k);
        checks++;
        if (mem_wdata !== e_data) begin
          errors++;
          $display("FAIL mem_wdata t=%0d got %h exp %h", t, mem_wdata, e_data);
        end
      end
      if (e_ctrl[0]) begin
        e_data = 16'((ea + k - 1) % 65536) ^ ld_key;
        checks++;
        if ({vrf_waddr, vrf_welem, vrf_wdata} !== {vd, 4'(k - 1), e_data}) begin
          errors++;
          $display("FAIL vrf_write t=%0d got %0d/%0d/%h exp %0d/%0d/%h",
                   t, vrf_waddr, vrf_welem, vrf_wdata, vd, k - 1, e_data);
        end
      end
      if (t == n + 1) begin
        checks++;
        if (int'(perf_stall_cnt) !== perf_expect()) begin
          errors++;
          $display("FAIL perf_cnt got %0d exp %0d", perf_stall_cnt, perf_expect());
        end
      end
      if (t <= n) exp_stalls++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_stalls = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b1; functype = VLD; cycle_count = VLD_CYCLES;
    offset = 6'd0; base_data = 16'h1234; vdst_addr = 3'd1; vsrc_addr = 3'd2;
    #3;
    checks++;
    if ({stall, mem_addr, mem_re, mem_we, mem_wdata, vrf_raddr, vrf_relem, vrf_we,
         vrf_waddr, vrf_welem, vrf_wdata, busy, perf_stall_cnt} !== 83'd0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b busy=%b re=%b we=%b vwe=%b exp all zero",
               stall, busy, mem_re, mem_we, vrf_we);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; instr_valid = 1'b0;
    #1;
    checks++;
    if ({stall, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release stall/busy got %b exp 00", {stall, busy});
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      functype = 4'($urandom);
      if (is_vmem_op(functype)) instr_valid = 1'b0;
      else instr_valid = 1'b1;
      #1;
      checks++;
      if ({stall, busy, mem_we, mem_re, vrf_we} !== 5'd0) begin
        errors++;
        $display("FAIL passthrough op=%h valid=%b ctrl got %b exp 00000",
                 functype, instr_valid, {stall, busy, mem_we, mem_re, vrf_we});
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_vst();
    exec_op(1'b1, 16'h0100, 6'b111110, VST_CYCLES, 3'd2, 3'd0);
  endtask

  task automatic test_vld();
    exec_op(1'b0, 16'h0200, 6'd5, VLD_CYCLES, 3'd3, 3'd6);
  endtask

  task automatic test_wrap();
    exec_op(1'b0, 16'hFFFC, 6'd0, VLD_CYCLES, 3'd7, 3'd0);
  endtask

  task automatic test_back_to_back();
    exec_op(1'b1, 16'h3000, 6'd31, VST_CYCLES, 3'd0, 3'd5);
    @(negedge clk);
    instr_valid = 1'b1; functype = VADD;
    #1;
    checks++;
    if ({stall, busy, mem_we, mem_re, vrf_we} !== 5'd0) begin
      errors++;
      $display("FAIL vadd_after_vst ctrl got %b exp 00000", {stall, busy, mem_we, mem_re, vrf_we});
    end
    exec_op(1'b0, 16'h4000, 6'd1, VLD_CYCLES, 3'd4, 3'd0);
    exec_op(1'b1, 16'h5000, 6'd63, VST_CYCLES, 3'd0, 3'd3);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    for (int t = 0; t <= 8; t++) begin
      @(negedge clk);
      instr_valid = 1'b1; functype = VST; base_data = 16'h0700; offset = 6'd0;
      cycle_count = VST_CYCLES; vdst_addr = 3'd0; vsrc_addr = 3'd1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, mem_addr, mem_re, mem_we, mem_wdata, vrf_raddr, vrf_relem, vrf_we,
         vrf_waddr, vrf_welem, vrf_wdata, busy, perf_stall_cnt} !== 83'd0) begin
      errors++;
      $display("FAIL async_reset stall=%b busy=%b we=%b addr=%h exp all zero",
               stall, busy, mem_we, mem_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({stall, busy, mem_we, mem_re, vrf_we} !== 5'd0) begin
      errors++;
      $display("FAIL reset_held ctrl got %b exp 00000", {stall, busy, mem_we, mem_re, vrf_we});
    end
    @(negedge clk);
    rst_n = 1'b1; instr_valid = 1'b0;
    exp_stalls = 0;
    #1;
    checks++;
    if ({stall, busy} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle stall/busy got %b exp 00", {stall, busy});
    end
    exec_op(1'b0, 16'h0800, 6'd2, VLD_CYCLES, 3'd5, 3'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      ld_key = 16'($urandom);
      exec_op(1'($urandom), 16'($urandom), 6'($urandom), 5'($urandom_range(0, 31)),
              3'($urandom), 3'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        checks++;
        if ({stall, busy, mem_we, mem_re, vrf_we} !== 5'd0) begin
          errors++;
          $display("FAIL random_gap op=%0d ctrl got %b exp 00000", i,
                   {stall, busy, mem_we, mem_re, vrf_we});
        end
      end
    end
    ld_key = 16'h5555;
  endtask

  task automatic test_perf();
    int exp_cnt;
    apply_reset();
    exec_op(1'b0, 16'h0200, 6'd5, VLD_CYCLES, 3'd1, 3'd0);
    exec_op(1'b1, 16'h0100, 6'b111110, VST_CYCLES, 3'd0, 3'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
`ifdef VMEM_SEQ_PERF_CNT_EN
    exp_cnt = 33;
`else
    exp_cnt = 0;
`endif
    checks++;
    if (int'(perf_stall_cnt) !== exp_cnt) begin
      errors++;
      $display("FAIL perf_vld_vst got %0d exp %0d", perf_stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_vst();
    test_vld();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
